// File: rtl/ysyx_22040237_defs.sv
// Shared constants and types for the ysyx_22040237 instruction fetch unit.
package ysyx_22040237_defs;

   localparam int unsigned INST_W = 32;
   localparam int unsigned XLEN   = 64;

   localparam logic [63:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;

   typedef enum logic [1:0] {
      StReq  = 2'd0,
      StWait = 2'd1,
      StHold = 2'd2
   } ifu_state_e;

endpackage

// File: rtl/ysyx_22040237_pc_reg.sv
// Program counter register: synchronous reset, redirect load and sequential +4 advance.
module ysyx_22040237_pc_reg
   import ysyx_22040237_defs::*;
#(
   parameter logic [63:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            inc,
   input  logic            load,
   input  logic [XLEN-1:0] load_pc,
   output logic [XLEN-1:0] pc
);

   logic [XLEN-1:0] pc_q;

   // Redirect wins over sequential advance; the adder wraps modulo 2^64.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q <= RESET_PC;
      end else if (load) begin
         pc_q <= load_pc;
      end else if (inc) begin
         pc_q <= pc_q + 64'd4;
      end
   end

   assign pc = pc_q;

endmodule

// File: rtl/ysyx_22040237_ifu.sv
// Instruction fetch unit: one outstanding fetch, holds the word until decode accepts it,
// and squashes in-flight or held instructions on an execute-stage redirect.
module ysyx_22040237_ifu
   import ysyx_22040237_defs::*;
#(
   parameter logic [63:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   output logic              imem_req_valid,
   input  logic              imem_req_ready,
   output logic [XLEN-1:0]   imem_req_addr,
   input  logic              imem_rsp_valid,
   input  logic [INST_W-1:0] imem_rsp_data,
   output logic              inst_valid,
   output logic [INST_W-1:0] inst,
   output logic [XLEN-1:0]   inst_pc,
   input  logic              idu_ready,
   input  logic              redirect_valid,
   input  logic [XLEN-1:0]   redirect_pc,
   output logic [XLEN-1:0]   inst_cnt
);

   ifu_state_e        state_q, state_d;
   logic              drop_q, drop_d;
   logic [INST_W-1:0] inst_q;
   logic [XLEN-1:0]   inst_pc_q;
   logic [XLEN-1:0]   inst_cnt_q;
   logic [XLEN-1:0]   pc;
   logic              pc_inc, pc_load, capture;

   ysyx_22040237_pc_reg #(
      .RESET_PC (RESET_PC)
   ) u_pc_reg (
      .clk     (clk),
      .rst     (rst),
      .inc     (pc_inc),
      .load    (pc_load),
      .load_pc (redirect_pc),
      .pc      (pc)
   );

   always_comb begin
      state_d = state_q;
      drop_d  = drop_q;
      pc_inc  = 1'b0;
      pc_load = 1'b0;
      capture = 1'b0;
      unique case (state_q)
         StReq: begin
            if (redirect_valid) begin
               pc_load = 1'b1;
            end else if (imem_req_ready) begin
               state_d = StWait;
            end
         end
         StWait: begin
            if (redirect_valid) begin
               pc_load = 1'b1;
               // A response landing with the redirect belongs to the squashed path.
               if (imem_rsp_valid) begin
                  state_d = StReq;
                  drop_d  = 1'b0;
               end else begin
                  drop_d  = 1'b1;
               end
            end else if (imem_rsp_valid) begin
               if (drop_q) begin
                  state_d = StReq;
                  drop_d  = 1'b0;
               end else begin
                  capture = 1'b1;
                  state_d = StHold;
               end
            end
         end
         StHold: begin
            if (redirect_valid) begin
               pc_load = 1'b1;
               state_d = StReq;
            end else if (idu_ready) begin
               pc_inc  = 1'b1;
               state_d = StReq;
            end
         end
         default: state_d = StReq;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StReq;
         drop_q     <= 1'b0;
         inst_q     <= '0;
         inst_pc_q  <= '0;
         inst_cnt_q <= '0;
      end else begin
         state_q <= state_d;
         drop_q  <= drop_d;
         if (capture) begin
            inst_q    <= imem_rsp_data;
            inst_pc_q <= pc;
         end
         if (pc_inc) begin
            inst_cnt_q <= inst_cnt_q + 64'd1;
         end
      end
   end

   assign imem_req_valid = (state_q == StReq) & ~redirect_valid & ~rst;
   assign imem_req_addr  = pc;
   assign inst_valid     = (state_q == StHold) & ~redirect_valid & ~rst;
   assign inst           = inst_q;
   assign inst_pc        = inst_pc_q;
   assign inst_cnt       = inst_cnt_q;

endmodule

// File: tb/tb_ysyx_22040237_ifu.sv
// Self-checking bench for ysyx_22040237_ifu: directed scenarios plus a randomized run
// checked against a transaction-level model of fetch, hand-off and redirect.
module tb_ysyx_22040237_ifu;

   logic        clk;
   logic        rst;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [63:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        inst_valid;
   logic [31:0] inst;
   logic [63:0] inst_pc;
   logic        idu_ready;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic [63:0] inst_cnt;

   int checks = 0;
   int errors = 0;

   ysyx_22040237_ifu #(
      .RESET_PC (64'h0000_0000_8000_0000)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .inst_valid     (inst_valid),
      .inst           (inst),
      .inst_pc        (inst_pc),
      .idu_ready      (idu_ready),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .inst_cnt       (inst_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      idu_ready      = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      #1;
   endtask

   // Issue one request (accepted at once) and return data the next cycle; ends in HOLD.
   task automatic fetch_to_hold(input logic [31:0] d);
      imem_req_ready = 1'b1;
      tick();
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = d;
      tick();
      imem_rsp_valid = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      fetch_to_hold(32'h1111_1111);
      idu_ready = 1'b1;
      tick();
      idu_ready = 1'b0;
      fetch_to_hold(32'h2222_2222);
      rst = 1'b1;
      idu_ready = 1'b1;
      imem_req_ready = 1'b1;
      #1;
      checks++;
      if (inst_valid !== 1'b0) begin
         errors++; $display("FAIL rst_inst_valid got %0b want 0", inst_valid);
      end
      checks++;
      if (imem_req_valid !== 1'b0) begin
         errors++; $display("FAIL rst_req_valid got %0b want 0", imem_req_valid);
      end
      tick();
      checks++;
      if (inst !== 32'h0 || inst_pc !== 64'h0 || inst_cnt !== 64'h0) begin
         errors++;
         $display("FAIL rst_regs got inst=%h pc=%h cnt=%0d want 0/0/0", inst, inst_pc, inst_cnt);
      end
      rst = 1'b0;
      imem_req_ready = 1'b0;
      idu_ready = 1'b0;
      #1;
      checks++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0000) begin
         errors++;
         $display("FAIL rst_first_req got v=%0b a=%h want 1/80000000",
                  imem_req_valid, imem_req_addr);
      end
   endtask

   task automatic test_zero_wait();
      do_reset();
      imem_req_ready = 1'b1;
      #1;
      checks++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0000) begin
         errors++;
         $display("FAIL zw_c0_req got v=%0b a=%h want 1/80000000", imem_req_valid, imem_req_addr);
      end
      tick();
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'h0010_0093;
      #1;
      checks++;
      if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
         errors++;
         $display("FAIL zw_c1 got req=%0b iv=%0b want 0/0", imem_req_valid, inst_valid);
      end
      tick();
      imem_rsp_valid = 1'b0;
      idu_ready = 1'b1;
      #1;
      checks++;
      if (inst_valid !== 1'b1 || inst !== 32'h0010_0093 || inst_pc !== 64'h8000_0000) begin
         errors++;
         $display("FAIL zw_c2 got iv=%0b inst=%h pc=%h want 1/00100093/80000000",
                  inst_valid, inst, inst_pc);
      end
      tick();
      idu_ready = 1'b0;
      #1;
      checks++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0004 || inst_cnt !== 64'd1) begin
         errors++;
         $display("FAIL zw_c3 got v=%0b a=%h cnt=%0d want 1/80000004/1",
                  imem_req_valid, imem_req_addr, inst_cnt);
      end
   endtask

   task automatic test_idu_stall();
      do_reset();
      fetch_to_hold(32'hDEAD_BEEF);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (inst_valid !== 1'b1 || inst !== 32'hDEAD_BEEF || inst_pc !== 64'h8000_0000 ||
             imem_req_valid !== 1'b0 || inst_cnt !== 64'd0) begin
            errors++;
            $display("FAIL stall_%0d got iv=%0b inst=%h pc=%h req=%0b cnt=%0d", i,
                     inst_valid, inst, inst_pc, imem_req_valid, inst_cnt);
         end
         tick();
      end
      idu_ready = 1'b1;
      tick();
      idu_ready = 1'b0;
      #1;
      checks++;
      if (inst_cnt !== 64'd1 || imem_req_addr !== 64'h8000_0004 || imem_req_valid !== 1'b1) begin
         errors++;
         $display("FAIL stall_accept got cnt=%0d a=%h v=%0b want 1/80000004/1",
                  inst_cnt, imem_req_addr, imem_req_valid);
      end
   endtask

   task automatic test_redirect_wait();
      do_reset();
      imem_req_ready = 1'b1;
      tick();
      imem_req_ready = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = 64'h8000_1000;
      #1;
      checks++;
      if (imem_req_valid !== 1'b0) begin
         errors++; $display("FAIL rw_req_during got %0b want 0", imem_req_valid);
      end
      tick();
      redirect_valid = 1'b0;
      repeat (2) tick();
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'hBAD0_BAD0;
      tick();
      imem_rsp_valid = 1'b0;
      #1;
      checks++;
      if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_1000 ||
          inst_cnt !== 64'd0) begin
         errors++;
         $display("FAIL rw_dropped got iv=%0b req=%0b a=%h cnt=%0d want 0/1/80001000/0",
                  inst_valid, imem_req_valid, imem_req_addr, inst_cnt);
      end
      fetch_to_hold(32'h1234_5678);
      checks++;
      if (inst_valid !== 1'b1 || inst !== 32'h1234_5678 || inst_pc !== 64'h8000_1000) begin
         errors++;
         $display("FAIL rw_refetch got iv=%0b inst=%h pc=%h want 1/12345678/80001000",
                  inst_valid, inst, inst_pc);
      end
   endtask

   task automatic test_redirect_hold();
      do_reset();
      fetch_to_hold(32'hAAAA_5555);
      redirect_valid = 1'b1;
      redirect_pc    = 64'h8000_2000;
      idu_ready      = 1'b1;
      #1;
      checks++;
      if (inst_valid !== 1'b0) begin
         errors++; $display("FAIL rh_inst_valid got %0b want 0", inst_valid);
      end
      tick();
      redirect_valid = 1'b0;
      idu_ready      = 1'b0;
      #1;
      checks++;
      if (inst_cnt !== 64'd0 || imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_2000) begin
         errors++;
         $display("FAIL rh_after got cnt=%0d v=%0b a=%h want 0/1/80002000",
                  inst_cnt, imem_req_valid, imem_req_addr);
      end
   endtask

   task automatic test_req_backpressure();
      do_reset();
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0000) begin
            errors++;
            $display("FAIL bp_hold_%0d got v=%0b a=%h want 1/80000000",
                     i, imem_req_valid, imem_req_addr);
         end
         tick();
      end
      imem_req_ready = 1'b1;
      tick();
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_wait_%0d got req=%0b iv=%0b want 0/0", i, imem_req_valid, inst_valid);
         end
         tick();
      end
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'h0BAD_F00D;
      tick();
      imem_rsp_valid = 1'b0;
      #1;
      checks++;
      if (inst_valid !== 1'b1 || inst !== 32'h0BAD_F00D || inst_pc !== 64'h8000_0000) begin
         errors++;
         $display("FAIL bp_hold got iv=%0b inst=%h pc=%h want 1/0badf00d/80000000",
                  inst_valid, inst, inst_pc);
      end
   endtask

   task automatic test_reset_in_wait();
      do_reset();
      imem_req_ready = 1'b1;
      tick();
      imem_req_ready = 1'b0;
      rst = 1'b1;
      #1;
      checks++;
      if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
         errors++;
         $display("FAIL rwt_during got req=%0b iv=%0b want 0/0", imem_req_valid, inst_valid);
      end
      tick();
      rst = 1'b0;
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'h57A1_E000;
      tick();
      imem_rsp_valid = 1'b0;
      #1;
      checks++;
      if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0000) begin
         errors++;
         $display("FAIL rwt_stale got iv=%0b req=%0b a=%h want 0/1/80000000",
                  inst_valid, imem_req_valid, imem_req_addr);
      end
      fetch_to_hold(32'h0000_0013);
      checks++;
      if (inst !== 32'h0000_0013 || inst_pc !== 64'h8000_0000) begin
         errors++;
         $display("FAIL rwt_fresh got inst=%h pc=%h want 00000013/80000000", inst, inst_pc);
      end
   endtask

   task automatic test_pc_wrap();
      do_reset();
      redirect_valid = 1'b1;
      redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
      imem_req_ready = 1'b1;
      #1;
      checks++;
      if (imem_req_valid !== 1'b0) begin
         errors++; $display("FAIL wrap_req_on_redirect got %0b want 0", imem_req_valid);
      end
      tick();
      redirect_valid = 1'b0;
      imem_req_ready = 1'b0;
      fetch_to_hold(32'hCAFE_0001);
      checks++;
      if (inst_pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin
         errors++; $display("FAIL wrap_inst_pc got %h want fffffffffffffffc", inst_pc);
      end
      idu_ready = 1'b1;
      tick();
      idu_ready = 1'b0;
      #1;
      checks++;
      if (imem_req_addr !== 64'h0 || inst_cnt !== 64'd1) begin
         errors++;
         $display("FAIL wrap_next got a=%h cnt=%0d want 0/1", imem_req_addr, inst_cnt);
      end
   endtask

   // Randomized run against a transaction model: at most one fetch in flight, a redirect
   // retargets the next fetch and kills whatever is in flight or held.
   task automatic test_random();
      logic [63:0] m_pc;
      logic [63:0] m_cnt;
      logic [63:0] m_rpc;
      logic [31:0] m_rdata;
      logic [63:0] m_hpc;
      logic [31:0] m_hdata;
      logic        m_out, m_kill, m_held, exp_req, exp_iv;
      int          cd;
      do_reset();
      m_pc = 64'h8000_0000; m_cnt = '0; m_out = 0; m_kill = 0; m_held = 0; cd = 0;
      m_rpc = '0; m_rdata = '0; m_hpc = '0; m_hdata = '0;
      for (int c = 0; c < 3000; c++) begin
         redirect_valid = ($urandom_range(0, 15) == 0);
         redirect_pc = ($urandom_range(0, 7) == 0) ? 64'hFFFF_FFFF_FFFF_FFFC :
                       ({$urandom(), $urandom()} & ~64'h3);
         imem_req_ready = ($urandom_range(0, 2) != 0);
         idu_ready      = ($urandom_range(0, 2) != 0);
         if (m_out && cd == 1) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = m_rdata;
         end else begin
            if (m_out) cd--;
            // Stray responses while nothing is in flight must be ignored.
            imem_rsp_valid = !m_out && ($urandom_range(0, 7) == 0);
            imem_rsp_data  = $urandom();
         end
         @(negedge clk);
         exp_req = !m_out && !m_held && !redirect_valid;
         exp_iv  = m_held && !redirect_valid;
         checks++;
         if (imem_req_valid !== exp_req || (exp_req && imem_req_addr !== m_pc)) begin
            errors++;
            $display("FAIL rnd_req cyc %0d got v=%0b a=%h want v=%0b a=%h",
                     c, imem_req_valid, imem_req_addr, exp_req, m_pc);
         end
         checks++;
         if (inst_valid !== exp_iv || (exp_iv && (inst_pc !== m_hpc || inst !== m_hdata))) begin
            errors++;
            $display("FAIL rnd_inst cyc %0d got v=%0b pc=%h i=%h want v=%0b pc=%h i=%h",
                     c, inst_valid, inst_pc, inst, exp_iv, m_hpc, m_hdata);
         end
         checks++;
         if (inst_cnt !== m_cnt) begin
            errors++; $display("FAIL rnd_cnt cyc %0d got %0d want %0d", c, inst_cnt, m_cnt);
         end
         if (imem_rsp_valid && m_out) begin
            m_out = 1'b0;
            if (!m_kill && !redirect_valid) begin
               m_held = 1'b1; m_hpc = m_rpc; m_hdata = imem_rsp_data;
            end
         end
         if (redirect_valid) begin
            m_pc = redirect_pc;
            if (m_out) m_kill = 1'b1;
            m_held = 1'b0;
         end else if (exp_iv && idu_ready) begin
            m_cnt = m_cnt + 64'd1;
            m_pc  = m_pc + 64'd4;
            m_held = 1'b0;
         end
         if (exp_req && imem_req_ready) begin
            m_out = 1'b1; m_kill = 1'b0; m_rpc = m_pc;
            m_rdata = $urandom();
            cd = $urandom_range(1, 3);
         end
         @(posedge clk);
         #1;
      end
      checks++;
      if (m_cnt < 64'd50) begin
         errors++; $display("FAIL rnd_progress got %0d accepts want >= 50", m_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_zero_wait();
      test_idu_stall();
      test_redirect_wait();
      test_redirect_hold();
      test_req_backpressure();
      test_reset_in_wait();
      test_pc_wrap();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
